// File: rtl/mips_step_controller_pkg.sv
// Shared types and default constants for the MIPS instruction step controller.
// The state encoding is fixed so debug logic can decode it directly.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_EXEC      = 2'b01,
    ST_WAIT_STEP = 2'b10,
    ST_HALTED    = 2'b11
  } state_e;

  localparam int PC_W             = 32;
  localparam int CYCLES_PER_INSTR = 30;
  localparam int CNT_W            = 8;
  localparam int MAX_INSTR        = 109;
  localparam int ICNT_W           = 32;

endpackage

// File: rtl/mips_step_controller_if.sv
// Control/status bundle between bench or debug control (master) and the step controller (slave).
interface mips_step_controller_if #(
  parameter int PC_W = 32
);
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            step_mode;
  logic            step;
  logic            halt_req;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            retire;
  logic            busy;
  logic            halted;
  logic [31:0]     instr_count;

  modport master (
    output start, start_pc, step_mode, step, halt_req, redirect_valid, redirect_pc,
    input  pc, instr_valid, retire, busy, halted, instr_count
  );

  modport slave (
    input  start, start_pc, step_mode, step, halt_req, redirect_valid, redirect_pc,
    output pc, instr_valid, retire, busy, halted, instr_count
  );
endinterface

// File: rtl/mips_step_controller_timer.sv
// Per-instruction cycle counter; 'last' flags the final hold cycle of the current PC.
module instr_cycle_timer #(
  parameter int CNT_W  = 8,
  parameter int CYCLES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(CYCLES - 1));
endmodule

// File: rtl/mips_step_controller.sv
// Instruction sequencer: holds each PC for CYCLES_PER_INSTR clocks, then advances or redirects.
// Supports free-run, single-step, halt request and an auto-halt retirement limit.
module mips_step_controller
  import mips_ctrl_pkg::*;
#(
  parameter int PC_W             = mips_ctrl_pkg::PC_W,
  parameter int CYCLES_PER_INSTR = mips_ctrl_pkg::CYCLES_PER_INSTR,
  parameter int CNT_W            = mips_ctrl_pkg::CNT_W,
  parameter int MAX_INSTR        = mips_ctrl_pkg::MAX_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_step_controller_if.slave  bus
);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              retire_q, retire_d;
  logic              instr_valid_q, busy_q, halted_q;
  logic              last;
  logic [ICNT_W-1:0] icnt_inc;
  logic              hit_max;

  // Counter is held at zero outside EXEC, so every EXEC entry starts at cycle 0.
  instr_cycle_timer #(
    .CNT_W  (CNT_W),
    .CYCLES (CYCLES_PER_INSTR)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q != ST_EXEC) || last),
    .en    (state_q == ST_EXEC),
    .last  (last)
  );

  assign icnt_inc = icnt_q + ICNT_W'(1);
  assign hit_max  = (MAX_INSTR != 0) && (icnt_inc == ICNT_W'(MAX_INSTR));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    icnt_d      = icnt_q;
    halt_pend_d = halt_pend_q;
    retire_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        halt_pend_d = 1'b0;
        if (bus.start) begin
          pc_d    = bus.start_pc;
          icnt_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        halt_pend_d = halt_pend_q | bus.halt_req;
        if (last) begin
          pc_d        = bus.redirect_valid ? bus.redirect_pc : pc_q + PC_W'(1);
          icnt_d      = icnt_inc;
          retire_d    = 1'b1;
          halt_pend_d = 1'b0;
          if (halt_pend_q || bus.halt_req || hit_max) state_d = ST_HALTED;
          else if (bus.step_mode)                     state_d = ST_WAIT_STEP;
          else                                        state_d = ST_EXEC;
        end
      end
      ST_WAIT_STEP: begin
        if (bus.halt_req)                        state_d = ST_HALTED;
        else if (bus.step || !bus.step_mode)     state_d = ST_EXEC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      icnt_q        <= '0;
      halt_pend_q   <= 1'b0;
      retire_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      icnt_q        <= icnt_d;
      halt_pend_q   <= halt_pend_d;
      retire_q      <= retire_d;
      instr_valid_q <= (state_d == ST_EXEC);
      busy_q        <= (state_d == ST_EXEC) || (state_d == ST_WAIT_STEP);
      halted_q      <= (state_d == ST_HALTED);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.retire      = retire_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = icnt_q;
endmodule

// File: tb/tb_mips_step_controller.sv
// Directed plus randomized bench for mips_step_controller against an instruction-level model.
module tb_mips_step_controller;
  localparam int N    = 30;
  localparam int MAXI = 109;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_step_controller_if #(.PC_W(32)) bus ();

  mips_step_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: one of idle / running / waiting / stopped, plus cycles spent on the current PC.
  bit          m_running, m_waiting, m_stopped, m_ret, m_hp;
  int          m_age;
  logic [31:0] m_pc, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit was_halt;
    if (!rst_n) begin
      m_running = 0; m_waiting = 0; m_stopped = 0; m_ret = 0; m_hp = 0;
      m_age = 0; m_pc = 0; m_count = 0;
    end else if (m_running) begin
      was_halt = m_hp || bus.halt_req;
      m_ret = 0;
      if (m_age == N - 1) begin
        m_pc    = bus.redirect_valid ? bus.redirect_pc : m_pc + 1;
        m_count = m_count + 1;
        m_ret   = 1;
        m_age   = 0;
        m_hp    = 0;
        if (was_halt || m_count == MAXI) begin
          m_running = 0; m_stopped = 1;
        end else if (bus.step_mode) begin
          m_running = 0; m_waiting = 1;
        end
      end else begin
        m_hp  = was_halt;
        m_age = m_age + 1;
      end
    end else if (m_waiting) begin
      m_ret = 0;
      if (bus.halt_req) begin
        m_waiting = 0; m_stopped = 1;
      end else if (bus.step || !bus.step_mode) begin
        m_waiting = 0; m_running = 1; m_age = 0;
      end
    end else begin
      m_ret = 0;
      m_hp  = 0;
      if (bus.start) begin
        m_pc = bus.start_pc; m_count = 0; m_age = 0;
        m_running = 1; m_stopped = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc",          bus.pc,                m_pc);
    chk("instr_valid", 32'(bus.instr_valid),  32'(m_running));
    chk("busy",        32'(bus.busy),         32'(m_running | m_waiting));
    chk("halted",      32'(bus.halted),       32'(m_stopped));
    chk("retire",      32'(bus.retire),       32'(m_ret));
    chk("instr_count", bus.instr_count,       m_count);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic run_until_age(input int a);
    int i;
    for (i = 0; i < 400 && !(m_running && m_age == a); i++) tick();
    if (!(m_running && m_age == a)) timeout("wait_age");
  endtask

  task automatic run_until_retire();
    int i;
    for (i = 0; i < 400; i++) begin
      tick();
      if (m_ret) break;
    end
    if (!m_ret) timeout("wait_retire");
  endtask

  task automatic pulse_start(input logic [31:0] spc);
    bus.start_pc = spc; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic halt_now();
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    run_until_retire();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b1; bus.start_pc = 32'h55; bus.step_mode = 1'b0; bus.step = 1'b0;
    bus.halt_req = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    @(negedge clk);

    // Reset with start held
    repeat (3) tick();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_count", bus.instr_count, 32'h0);
    bus.start = 1'b0; rst_n = 1'b1;
    tick();

    // Free-run to the retirement limit
    pulse_start(32'h0);
    chk("fr_pc0", bus.pc, 32'h0);
    repeat (N - 1) tick();
    chk("fr_pc_hold", bus.pc, 32'h0);
    tick();
    chk("fr_pc1", bus.pc, 32'h1);
    chk("fr_retire", 32'(bus.retire), 32'h1);
    repeat (MAXI * N) tick();
    chk("fr_halted", 32'(bus.halted), 32'h1);
    chk("fr_pc_end", bus.pc, 32'h6D);
    chk("fr_count_end", bus.instr_count, 32'd109);

    // Redirect on last cycle, then off-last-cycle
    pulse_start(32'h5);
    run_until_age(N - 1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_taken", bus.pc, 32'h40);
    halt_now();
    pulse_start(32'h5);
    run_until_age(10);
    bus.redirect_valid = 1'b1; tick(); bus.redirect_valid = 1'b0;
    run_until_retire();
    chk("redir_ignored", bus.pc, 32'h6);
    halt_now();

    // Single step
    bus.step_mode = 1'b1;
    pulse_start(32'h20);
    run_until_retire();
    repeat (50) tick();
    chk("step_pc_held", bus.pc, 32'h21);
    chk("step_iv_low", 32'(bus.instr_valid), 32'h0);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("step_exec", 32'(bus.instr_valid), 32'h1);
    run_until_age(5);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("step_ignored_busy", 32'(bus.busy), 32'h1);
    bus.step_mode = 1'b0;
    run_until_retire();
    halt_now();

    // Halt request mid-instruction, then restart
    pulse_start(32'h3);
    run_until_age(10);
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    run_until_retire();
    chk("halt_pc", bus.pc, 32'h4);
    chk("halt_flag", 32'(bus.halted), 32'h1);
    pulse_start(32'h10);
    chk("restart_pc", bus.pc, 32'h10);
    chk("restart_count", bus.instr_count, 32'h0);
    chk("restart_busy", 32'(bus.busy), 32'h1);

    // Reset mid-instruction, then PC wrap
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pulse_start(32'h7);
    run_until_age(15);
    rst_n = 1'b0; tick();
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1; tick();
    chk("midrst_no_retire", 32'(bus.retire), 32'h0);
    pulse_start(32'hFFFF_FFFF);
    run_until_retire();
    chk("pc_wrap", bus.pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n              = ($urandom_range(0, 799) != 0);
      bus.start          = ($urandom_range(0, 39) == 0);
      bus.start_pc       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
      bus.step           = ($urandom_range(0, 19) == 0);
      bus.halt_req       = ($urandom_range(0, 149) == 0);
      bus.redirect_valid = ($urandom_range(0, 2) == 0);
      bus.redirect_pc    = $urandom;
      if ($urandom_range(0, 199) == 0) bus.step_mode = ~bus.step_mode;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
